riscv_operand_stage: RTL
========================

Name: riscv_operand_stage

Overview:
- Registered ID/EX operand stage.
- Selects ALU operand 1 and operand 2 from register data, PC, immediates or constants, and resolves RAW hazards by forwarding from later pipeline stages.
- Presents the result through one valid/ready pipeline register to the EX stage.
- Parametrised in data width and forwarding-source count; extends the operand-2 selection with new modes.

Parameters:
- XLEN, 32, datapath width in bits.
- NUM_FWD, 2, number of forwarding sources. Index 0 is the youngest stage (EX/MEM) and has the highest priority.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  decode has an operand bundle
- in_ready  out  1  stage can accept the bundle
- flush  in  1  kill the registered and incoming bundle (branch mispredict, trap)
- op1_sel  in  OP1_SEL  one of OP1_RS1, OP1_PC, OP1_ZERO
- op2_sel  in  OP2_SEL  one of OP2_RS2, OP2_IMI, OP2_IMS, OP2_IMU, OP2_FOUR
- pc  in  XLEN  PC of the instruction
- rs1_addr, rs2_addr  in  5  source register indices
- rs1_data, rs2_data  in  XLEN  register-file read data
- imm_i_sext, imm_s_sext, imm_u_sext  in  XLEN  pre-extended immediates
- fwd_valid  in  NUM_FWD  forwarding source carries a register write
- fwd_rd  in  NUM_FWD x 5  destination register of each source
- fwd_data  in  NUM_FWD x XLEN  result of each source
- out_valid  out  1  registered bundle valid
- out_ready  in  1  EX accepts the bundle
- op1, op2  out  XLEN  registered operands
- store_data  out  XLEN  registered forwarded rs2 value, used by stores whatever op2 selects

Behaviour:
- Reset: out_valid=0, op1=0, op2=0, store_data=0.
- Latency: one cycle from accepted input to registered output.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; no dependence on in_valid).
  - Load when in_valid && in_ready.
  - If the register holds a bundle and out_ready=0, op1/op2/store_data/out_valid hold unchanged.
  - If out_valid && out_ready && !in_valid, then out_valid clears next cycle; data may hold.
- Forwarding (per source operand, combinational before the register):
  - Pick the lowest index i with fwd_valid[i] && fwd_rd[i]==rsX_addr && rsX_addr!=0, then use fwd_data[i].
  - If no source matches, use rsX_data.
  - x0 always reads 0, even when rs1_data or rs2_data is nonzero.
- op1 mux: RS1 gives fwd_rs1; PC gives pc; ZERO gives 0; any undefined code gives 0.
- op2 mux: RS2 gives fwd_rs2; IMI gives imm_i_sext; IMS gives imm_s_sext; IMU gives imm_u_sext; FOUR gives XLEN'(4); any undefined code gives 0.
- store_data always captures fwd_rs2.
- flush:
  - The next cycle has out_valid=0, whether or not a bundle was held or offered.
  - Flush dominates a simultaneous load; the incoming bundle is discarded.
  - in_ready is unaffected by flush.
- rst dominates flush and load.
- A reset asserted mid-stall drops the held bundle.
- Widths: all datapath values are XLEN. The constant 4 is zero-extended. No arithmetic is performed in this block.

Optional Feature:
- Macro: RISCV_OPERAND_FWD_EN.
- Defined: forwarding as described above.
- Undefined:
  - fwd_valid, fwd_rd and fwd_data stay on the port list but are ignored.
  - fwd_rs1 = rs1_data and fwd_rs2 = rs2_data, with x0 still forced to 0.
  - The hazard unit must stall instead of forwarding.
  - Handshake and timing are otherwise identical.

Decomposition:
- Shared constants package holds:
  - the OP1_SEL enum (OP1_RS1, OP1_PC, OP1_ZERO);
  - the extended OP2_SEL enum (OP2_RS2, OP2_IMI, OP2_IMS, OP2_IMU, OP2_FOUR);
  - the x0 address constant.
- OP2_RS2, OP2_IMI and OP2_IMS keep their existing encodings.
- One sub-module, riscv_fwd_sel: a combinational priority match over NUM_FWD sources for one register index. It is instantiated twice, for rs1 and rs2.

Test Plan:
- Reset and basic select:
  - Assert rst for 2 cycles: out_valid=0, op1=op2=0.
  - Then offer op1_sel=OP1_PC, pc=0x100, op2_sel=OP2_FOUR: next cycle out_valid=1, op1=0x100, op2=0x4.
- Forward priority:
  - rs1_addr=5, rs1_data=0x11.
  - Source 0 {valid, rd 5, 0xAA}; source 1 {valid, rd 5, 0xBB}.
  - Required: op1=0xAA. With source 0 invalid: op1=0xBB.
- x0 protection:
  - rs2_addr=0, rs2_data=0xDEAD, source 0 {valid, rd 0, 0x55}, op2_sel=OP2_RS2.
  - Required: op2=0 and store_data=0.
- Backpressure:
  - Load bundle A (op2=imm_s_sext=0xFFFFFFF0), then hold out_ready=0 for 3 cycles while offering bundle B.
  - Required: in_ready=0, outputs hold A.
  - Then out_ready=1: A is consumed and B appears the next cycle.
- Flush with simultaneous load:
  - out_valid=1, out_ready=0, in_valid=1, flush=1.
  - Required: next cycle out_valid=0; the bundle is not presented later.
- Macro off:
  - Build without RISCV_OPERAND_FWD_EN and repeat the forward-priority stimulus.
  - Required: op1=0x11.

Source files
------------

// File: rtl/riscv_operand_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_operand_stage_pkg                                                    |
// | Operand-select encodings and register-index constants for the ID/EX stage. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package riscv_operand_stage_pkg;

  localparam logic [4:0] X0_ADDR = 5'd0;

  typedef enum logic [1:0] {
    OP1_RS1  = 2'd0,
    OP1_PC   = 2'd1,
    OP1_ZERO = 2'd2
  } op1_sel_e;

  // RS2/IMI/IMS keep their legacy codes; IMU and FOUR extend the space.
  typedef enum logic [2:0] {
    OP2_RS2  = 3'd0,
    OP2_IMI  = 3'd1,
    OP2_IMS  = 3'd2,
    OP2_IMU  = 3'd3,
    OP2_FOUR = 3'd4
  } op2_sel_e;

endpackage
`default_nettype wire

// File: rtl/riscv_fwd_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_fwd_sel                                                              |
// | Priority forwarding match for one source register (index 0 = youngest).    |
// | Forwarding is present only when RISCV_OPERAND_FWD_EN is defined.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module riscv_fwd_sel
  import riscv_operand_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic [4:0]                       rs_addr,
  input  logic [XLEN-1:0]                  rs_data,
  input  logic [NUM_FWD-1:0]               fwd_valid,
  input  logic [NUM_FWD-1:0][4:0]          fwd_rd,
  input  logic [NUM_FWD-1:0][XLEN-1:0]     fwd_data,
  output logic [XLEN-1:0]                  data
);

`ifdef RISCV_OPERAND_FWD_EN
  // Walk from oldest to youngest so the lowest matching index wins.
  always_comb begin
    data = rs_data;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_rd[i] == rs_addr)) begin
        data = fwd_data[i];
      end
    end
    if (rs_addr == X0_ADDR) begin
      data = '0;
    end
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{fwd_valid, fwd_rd, fwd_data};

  always_comb begin
    data = rs_data;
    if (rs_addr == X0_ADDR) begin
      data = '0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/riscv_operand_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_operand_stage                                                        |
// | Registered ID/EX operand select with forwarding and a valid/ready output.  |
// | Optional forwarding: RISCV_OPERAND_FWD_EN                                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module riscv_operand_stage
  import riscv_operand_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             flush,
  input  op1_sel_e                         op1_sel,
  input  op2_sel_e                         op2_sel,
  input  logic [XLEN-1:0]                  pc,
  input  logic [4:0]                       rs1_addr,
  input  logic [4:0]                       rs2_addr,
  input  logic [XLEN-1:0]                  rs1_data,
  input  logic [XLEN-1:0]                  rs2_data,
  input  logic [XLEN-1:0]                  imm_i_sext,
  input  logic [XLEN-1:0]                  imm_s_sext,
  input  logic [XLEN-1:0]                  imm_u_sext,
  input  logic [NUM_FWD-1:0]               fwd_valid,
  input  logic [NUM_FWD-1:0][4:0]          fwd_rd,
  input  logic [NUM_FWD-1:0][XLEN-1:0]     fwd_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [XLEN-1:0]                  op1,
  output logic [XLEN-1:0]                  op2,
  output logic [XLEN-1:0]                  store_data
);

  localparam logic [XLEN-1:0] C_FOUR = {{(XLEN-3){1'b0}}, 3'b100};

  logic [XLEN-1:0] w_fwd_rs1;
  logic [XLEN-1:0] w_fwd_rs2;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic            w_load;

  logic            r_out_valid;
  logic [XLEN-1:0] r_op1;
  logic [XLEN-1:0] r_op2;
  logic [XLEN-1:0] r_store_data;

  riscv_fwd_sel #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs1 (
    .rs_addr   (rs1_addr),
    .rs_data   (rs1_data),
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .data      (w_fwd_rs1)
  );

  riscv_fwd_sel #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs2 (
    .rs_addr   (rs2_addr),
    .rs_data   (rs2_data),
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .data      (w_fwd_rs2)
  );

  always_comb begin
    w_op1 = '0;
    case (op1_sel)
      OP1_RS1:  w_op1 = w_fwd_rs1;
      OP1_PC:   w_op1 = pc;
      OP1_ZERO: w_op1 = '0;
      default:  w_op1 = '0;
    endcase
  end

  always_comb begin
    w_op2 = '0;
    case (op2_sel)
      OP2_RS2:  w_op2 = w_fwd_rs2;
      OP2_IMI:  w_op2 = imm_i_sext;
      OP2_IMS:  w_op2 = imm_s_sext;
      OP2_IMU:  w_op2 = imm_u_sext;
      OP2_FOUR: w_op2 = C_FOUR;
      default:  w_op2 = '0;
    endcase
  end

  assign in_ready = !r_out_valid || out_ready;
  assign w_load   = in_valid && in_ready;

  // Flush kills both the held and the incoming bundle; data may stay stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_store_data <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
    end else if (w_load) begin
      r_out_valid  <= 1'b1;
      r_op1        <= w_op1;
      r_op2        <= w_op2;
      r_store_data <= w_fwd_rs2;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign op1        = r_op1;
  assign op2        = r_op2;
  assign store_data = r_store_data;

endmodule
`default_nettype wire
